// File: rtl/scanout_pkg.sv
// scanout_pkg: shared timing defaults, bank index type and channel-mask layout
package scanout_pkg;
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_BLANK  = 160;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_BLANK  = 45;
   localparam int CH_R = 2;
   localparam int CH_G = 1;
   localparam int CH_B = 0;
   typedef logic bank_t;
   function automatic int pix_w(input int ch_w);
      return 3 * ch_w;
   endfunction
endpackage

// File: rtl/scanout_pingpong_if.sv
// scanout_pingpong_if: producer write port, display controls and scan-out pixel stream
interface scanout_pingpong_if #(parameter int CH_W = 8) ();
   localparam int PIX_W = scanout_pkg::pix_w(CH_W);
   logic             en;
   logic             wr_valid;
   logic [PIX_W-1:0] wr_data;
   logic             wr_ready;
   logic [PIX_W-1:0] blank_color;
   logic [2:0]       ch_mask;
   logic             clear_underflow;
   logic [CH_W-1:0]  pix_r;
   logic [CH_W-1:0]  pix_g;
   logic [CH_W-1:0]  pix_b;
   logic             pix_valid;
   logic             hblank;
   logic             vblank;
   logic             line_start;
   logic             frame_start;
   logic [1:0]       buf_full;
   logic [1:0]       buf_empty;
   logic             underflow;
   modport master (
      output en, wr_valid, wr_data, blank_color, ch_mask, clear_underflow,
      input  wr_ready, pix_r, pix_g, pix_b, pix_valid, hblank, vblank,
             line_start, frame_start, buf_full, buf_empty, underflow
   );
   modport slave (
      input  en, wr_valid, wr_data, blank_color, ch_mask, clear_underflow,
      output wr_ready, pix_r, pix_g, pix_b, pix_valid, hblank, vblank,
             line_start, frame_start, buf_full, buf_empty, underflow
   );
endinterface

// File: rtl/scanout_timing.sv
// scanout_timing: px/line raster counters with enable gating and blanking/pulse decode
module scanout_timing #(
   parameter int H_ACTIVE = 640,
   parameter int H_BLANK  = 160,
   parameter int V_ACTIVE = 480,
   parameter int V_BLANK  = 45,
   parameter int CNT_W    = 10,
   parameter int AW       = 10
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_en,
   output logic [AW-1:0] o_col,
   output logic          o_col_last,
   output logic          o_active,
   output logic          o_hblank,
   output logic          o_vblank,
   output logic          o_line_start,
   output logic          o_frame_start
);
   localparam int H_TOTAL = H_ACTIVE + H_BLANK;
   localparam int V_TOTAL = V_ACTIVE + V_BLANK;
   if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_cnt_w_check
      $error("scanout_timing: CNT_W too narrow for H_TOTAL/V_TOTAL");
   end
   logic [CNT_W-1:0] r_px;
   logic [CNT_W-1:0] r_line;
   logic             w_px_wrap;
   logic             w_line_wrap;
   always_comb begin
      w_px_wrap     = r_px == CNT_W'(H_TOTAL - 1);
      w_line_wrap   = r_line == CNT_W'(V_TOTAL - 1);
      o_hblank      = r_px >= CNT_W'(H_ACTIVE);
      o_vblank      = r_line >= CNT_W'(V_ACTIVE);
      o_active      = !o_hblank && !o_vblank;
      o_col         = r_px[AW-1:0];
      o_col_last    = r_px == CNT_W'(H_ACTIVE - 1);
      o_line_start  = r_px == '0 && !o_vblank;
      o_frame_start = r_px == '0 && r_line == '0;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_px   <= '0;
         r_line <= '0;
      end else if (i_en) begin
         r_px <= w_px_wrap ? '0 : r_px + 1'b1;
         if (w_px_wrap) r_line <= w_line_wrap ? '0 : r_line + 1'b1;
      end
   end
endmodule

// File: rtl/scanout_pingpong.sv
// scanout_pingpong: ping-pong line banks filled by a ready/valid writer and drained by raster timing
module scanout_pingpong import scanout_pkg::*; #(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_BLANK  = DEF_H_BLANK,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_BLANK  = DEF_V_BLANK,
   parameter int CH_W     = 8,
   parameter int CNT_W    = 10
) (
   input  logic                clk,
   input  logic                reset,
   scanout_pingpong_if.slave   bus
);
   localparam int PIX_W = pix_w(CH_W);
   localparam int AW    = H_ACTIVE > 1 ? $clog2(H_ACTIVE) : 1;
   logic [PIX_W-1:0] r_mem [2][H_ACTIVE];
   bank_t            r_wsel;
   bank_t            r_rsel;
   logic [AW-1:0]    r_waddr;
   logic [1:0]       r_full;
   logic             r_line_ok;
   logic             r_underflow;
   logic [PIX_W-1:0] r_pix;
   logic             r_pix_valid;
   logic             r_hblank;
   logic             r_vblank;
   logic             r_line_start;
   logic             r_frame_start;
   logic [AW-1:0]    w_col;
   logic             w_col_last;
   logic             w_active;
   logic             w_hblank;
   logic             w_vblank;
   logic             w_line_start;
   logic             w_frame_start;
   logic             w_wr_ready;
   logic             w_wr_fire;
   logic             w_wr_done;
   logic             w_line_begin;
   logic             w_line_ok;
   logic             w_underrun;
   logic             w_release;
   logic [1:0]       w_set;
   logic [1:0]       w_clr;
   logic [PIX_W-1:0] w_mask;
   logic [PIX_W-1:0] w_src;
   logic [PIX_W-1:0] w_pix;
   scanout_timing #(
      .H_ACTIVE(H_ACTIVE), .H_BLANK(H_BLANK), .V_ACTIVE(V_ACTIVE),
      .V_BLANK(V_BLANK), .CNT_W(CNT_W), .AW(AW)
   ) u_timing (
      .clk(clk), .reset(reset), .i_en(bus.en),
      .o_col(w_col), .o_col_last(w_col_last), .o_active(w_active),
      .o_hblank(w_hblank), .o_vblank(w_vblank),
      .o_line_start(w_line_start), .o_frame_start(w_frame_start)
   );
   // The full/underrun decision is taken once at px 0 and held for the rest of the line.
   always_comb begin
      w_wr_ready   = !r_full[r_wsel];
      w_wr_fire    = bus.wr_valid && w_wr_ready;
      w_wr_done    = w_wr_fire && r_waddr == AW'(H_ACTIVE - 1);
      w_line_begin = bus.en && w_line_start;
      w_line_ok    = w_line_begin ? r_full[r_rsel] : r_line_ok;
      w_underrun   = w_line_begin && !r_full[r_rsel];
      w_release    = bus.en && w_active && w_col_last && w_line_ok;
      w_set        = w_wr_done ? 2'b01 << r_wsel : 2'b00;
      w_clr        = w_release ? 2'b01 << r_rsel : 2'b00;
      w_mask       = {{CH_W{bus.ch_mask[CH_R]}}, {CH_W{bus.ch_mask[CH_G]}}, {CH_W{bus.ch_mask[CH_B]}}};
      w_src        = w_line_ok ? r_mem[r_rsel][w_col] : bus.blank_color;
      w_pix        = bus.en && w_active ? w_src & w_mask : bus.blank_color;
   end
   always_ff @(posedge clk) begin
      if (w_wr_fire) r_mem[r_wsel][r_waddr] <= bus.wr_data;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wsel        <= '0;
         r_rsel        <= '0;
         r_waddr       <= '0;
         r_full        <= '0;
         r_line_ok     <= 1'b0;
         r_underflow   <= 1'b0;
         r_pix         <= '0;
         r_pix_valid   <= 1'b0;
         r_hblank      <= 1'b0;
         r_vblank      <= 1'b0;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         if (w_wr_fire) r_waddr <= w_wr_done ? '0 : r_waddr + 1'b1;
         if (w_wr_done) r_wsel <= ~r_wsel;
         if (w_release) r_rsel <= ~r_rsel;
         r_full        <= (r_full | w_set) & ~w_clr;
         r_line_ok     <= w_line_ok;
         r_underflow   <= w_underrun || (r_underflow && !bus.clear_underflow);
         r_pix         <= w_pix;
         r_pix_valid   <= bus.en && w_active;
         r_hblank      <= w_hblank;
         r_vblank      <= w_vblank;
         r_line_start  <= w_line_begin;
         r_frame_start <= bus.en && w_frame_start;
      end
   end
   assign bus.wr_ready    = w_wr_ready;
   assign bus.pix_r       = r_pix[3*CH_W-1:2*CH_W];
   assign bus.pix_g       = r_pix[2*CH_W-1:CH_W];
   assign bus.pix_b       = r_pix[CH_W-1:0];
   assign bus.pix_valid   = r_pix_valid;
   assign bus.hblank      = r_hblank;
   assign bus.vblank      = r_vblank;
   assign bus.line_start  = r_line_start;
   assign bus.frame_start = r_frame_start;
   assign bus.buf_full    = r_full;
   assign bus.buf_empty   = ~r_full;
   assign bus.underflow   = r_underflow;
endmodule

// File: doc/scanout_pingpong.md
Name: scanout_pingpong

Overview:
Parametrised display scan-out datapath with ping-pong line buffering. A producer streams packed RGB words into two line banks. An internal pixel/line timing generator reads one bank out as active video while the other bank fills. It generalises the fixed two-frame-buffer/FrameMUX datapath with configurable resolution, blanking and channel width. It adds a ready/valid write handshake, underflow detection and per-channel masking.

Parameters:
H_ACTIVE, 640, active pixels per line (= bank depth)
H_BLANK, 160, horizontal blanking pixels per line
V_ACTIVE, 480, active lines per frame
V_BLANK, 45, vertical blanking lines per frame
CH_W, 8, bits per colour channel; word width PIX_W = 3*CH_W, packed {R,G,B}
CNT_W, 10, counter width; must hold H_ACTIVE+H_BLANK-1 and V_ACTIVE+V_BLANK-1

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
en  in  1  display enable; timing advances only when high
wr_valid  in  1  write word offered
wr_data  in  PIX_W  packed {R,G,B} pixel
wr_ready  out  1  current write bank not full
blank_color  in  PIX_W  value driven during blanking and underrun
ch_mask  in  3  channel enables [2]=R [1]=G [0]=B; 0 forces that channel to 0 on active pixels
clear_underflow  in  1  clears sticky underflow
pix_r, pix_g, pix_b  out  CH_W each  pixel channels
pix_valid  out  1  active-area pixel slot
hblank  out  1  px >= H_ACTIVE
vblank  out  1  line >= V_ACTIVE
line_start  out  1  pulse on first pixel of each active line
frame_start  out  1  pulse on px 0, line 0
buf_full  out  2  per-bank full flags
buf_empty  out  2  per-bank not-full (~buf_full)
underflow  out  1  sticky underrun flag

Behaviour:
- H_TOTAL = H_ACTIVE+H_BLANK. V_TOTAL = V_ACTIVE+V_BLANK.
- px counts 0..H_TOTAL-1 and wraps to 0. line increments on the px wrap and wraps after V_TOTAL-1. Both advance only when en=1.
- Writer:
  - State is wsel (bank) and waddr.
  - wr_ready = ~buf_full[wsel] (combinational).
  - Each word is accepted when wr_valid && wr_ready, written to bank[wsel][waddr], and waddr increments.
  - Accepting at waddr = H_ACTIVE-1 sets buf_full[wsel], toggles wsel and clears waddr.
  - The writer runs regardless of en.
- Reader:
  - State is rsel (bank).
  - At the start of an active line (px=0, line<V_ACTIVE, en=1), the reader checks buf_full[rsel].
  - If the bank is full, it reads bank[rsel][px] on each active pixel. After the read at px = H_ACTIVE-1 it clears buf_full[rsel] and toggles rsel.
  - If the bank is not full, the line is an underrun: underflow is set, all H_ACTIVE pixels output blank_color, and rsel and buf_full are unchanged.
  - A partially written bank counts as not full.
- Latency:
  - Bank reads are synchronous, and all outputs are registered.
  - Outputs at cycle t+1 reflect the counter position at cycle t, and all outputs are mutually aligned.
- Outputs:
  - Active slot: pix_valid=1, data = bank data (or blank_color on underrun) with masked channels zeroed.
  - Blanking: pix_valid=0, data = blank_color unmasked.
  - en=0: counters hold; the next output is pix_valid=0, blank_color, hblank/vblank reflecting the held position, pulses 0.
- Simultaneous events:
  - A write completion on one bank and a read release on the other bank in the same cycle both take effect.
  - Same-bank conflict cannot occur: the reader only consumes full banks and the writer only targets non-full banks.
  - underflow set and clear_underflow in the same cycle: set wins.
- Reset (asynchronous, any time including mid-line or mid-write):
  - Counters, waddr, wsel and rsel go to 0.
  - buf_full=00, underflow=0.
  - pix_* = 0, pix_valid=0, hblank=0, vblank=0, line_start=0, frame_start=0.
  - wr_ready=1.
  - Bank contents are undefined and are not cleared.
- Width rules:
  - Address width is clog2(H_ACTIVE).
  - Counter compares use CNT_W-bit unsigned arithmetic.
  - A parameter check at elaboration fails if H_TOTAL or V_TOTAL exceeds 2^CNT_W.

Decomposition:
- Package scanout_pkg holds:
  - default timing constants (640/160/480/45);
  - a PIX_W helper function;
  - the bank-index typedef (1 bit);
  - the channel-mask bit positions.
- One sub-module, scanout_timing, holds the px/line counters, en gating, and the hblank/vblank/active/line_start/frame_start decode.
- Banks are inferred memories inside scanout_pingpong.

Test Plan:
All scenarios use H_ACTIVE=4, H_BLANK=2, V_ACTIVE=3, V_BLANK=1, CH_W=8.
1. Reset release -> wr_ready=1, buf_empty=2'b11, buf_full=2'b00, pix_valid=0, underflow=0, all pix_* = 0.
2. en=0; write 0x010101..0x040404 -> buf_full=2'b01. Write 4 more -> buf_full=2'b11, wr_ready=0, and a 9th wr_valid is not accepted.
3. Both banks full, en=1:
   - Line 0 gives 4 pix_valid cycles with data 0x01..0x04 in order, then 2 hblank cycles with blank_color.
   - line_start and frame_start pulse with the first pixel.
   - buf_full goes to 2'b10 after the 4th read and wr_ready=1.
4. Empty banks, en=1, blank_color=0xAAAAAA:
   - Line 0 gives 4 pix_valid cycles of 0xAAAAAA, and underflow=1 persists.
   - clear_underflow asserted in the same cycle as a new underrun leaves underflow=1; asserted alone, it gives 0.
5. Free-run 24 enabled cycles -> frame_start pulses again, vblank=1 for the 6 cycles of line 3, and pix_valid=0 throughout line 3.
6. Additional checks:
   - ch_mask=3'b101 with bank word 0x112233 -> pix_r=0x11, pix_g=0, pix_b=0x33.
   - Reset asserted at px=2 of an active line -> all outputs reset in the same cycle, and after release timing restarts at px 0, line 0.
